// File: rtl/ball_sprite.sv
// Per-ball pixel renderer: circular hit test against a frame-latched position,
// plus the visible / flashing / hidden lifecycle after the ball is pocketed.
module ball_sprite #(
  parameter int         BALL_SIZE    = 32,
  parameter logic [7:0] BALL_COLOR   = 8'hFF,
  parameter logic [7:0] EDGE_COLOR   = 8'h92,
  parameter int         FLASH_FRAMES = 16,
  parameter int         FLASH_PERIOD = 4
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  input  logic [10:0] topLeftX,
  input  logic [10:0] topLeftY,
  input  logic        startOfFrame,
  input  logic        sunk,
  input  logic        respawn,
  output logic        drawingRequest,
  output logic [7:0]  RGBout,
  output logic        visible,
  output logic        sunkDone
);

  localparam int                 PERIOD_BIT = $clog2(FLASH_PERIOD);
  localparam logic signed [11:0] SIZE_S     = 12'(BALL_SIZE);
  localparam logic signed [31:0] U_OFFSET   = 32'(BALL_SIZE - 1);
  localparam logic signed [31:0] R_OUTER    = 32'(BALL_SIZE * BALL_SIZE);
  localparam logic signed [31:0] R_INNER    = 32'((BALL_SIZE - 4) * (BALL_SIZE - 4));
  localparam logic [7:0]         LAST_FRAME = 8'(FLASH_FRAMES - 1);

  typedef enum logic [1:0] {
    ST_VISIBLE  = 2'd0,
    ST_FLASHING = 2'd1,
    ST_HIDDEN   = 2'd2
  } state_t;

  state_t      state_r;
  logic [7:0]  frame_cnt_r;
  logic [10:0] lat_x_r;
  logic [10:0] lat_y_r;

  logic signed [11:0] ox_s;
  logic signed [11:0] oy_s;
  logic signed [31:0] u_s;
  logic signed [31:0] v_s;
  logic signed [31:0] d_s;
  logic               in_box_s;
  logic               in_circle_s;
  logic               edge_hit_s;
  logic               draw_en_s;
  logic               draw_s;

  // Circle hit test; u and v are doubled offsets from the box centre so they stay integral.
  always_comb begin
    ox_s        = signed'({1'b0, pixelX}) - signed'({1'b0, lat_x_r});
    oy_s        = signed'({1'b0, pixelY}) - signed'({1'b0, lat_y_r});
    u_s         = 32'(ox_s) * 32'sd2 - U_OFFSET;
    v_s         = 32'(oy_s) * 32'sd2 - U_OFFSET;
    d_s         = u_s * u_s + v_s * v_s;
    in_box_s    = (ox_s >= 12'sd0) && (ox_s < SIZE_S) &&
                  (oy_s >= 12'sd0) && (oy_s < SIZE_S);
    in_circle_s = in_box_s && (d_s <= R_OUTER);
    edge_hit_s  = in_circle_s && (d_s > R_INNER);
  end

  // Draw enable from lifecycle state; flashing blinks on odd FLASH_PERIOD phases.
  always_comb begin
    case (state_r)
      ST_VISIBLE:  draw_en_s = 1'b1;
      ST_FLASHING: draw_en_s = frame_cnt_r[PERIOD_BIT];
      ST_HIDDEN:   draw_en_s = 1'b0;
      default:     draw_en_s = 1'b0;
    endcase
    draw_s = in_circle_s && draw_en_s;
  end

  // Registered pixel outputs, one cycle behind the raster coordinates.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      drawingRequest <= 1'b0;
      RGBout         <= 8'h00;
    end else begin
      drawingRequest <= draw_s;
      if (draw_s) begin
        RGBout <= edge_hit_s ? EDGE_COLOR : BALL_COLOR;
      end else begin
        RGBout <= 8'h00;
      end
    end
  end

  // Position latch and lifecycle FSM; respawn overrides everything else.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_r     <= ST_VISIBLE;
      frame_cnt_r <= 8'd0;
      lat_x_r     <= 11'd0;
      lat_y_r     <= 11'd0;
      visible     <= 1'b1;
      sunkDone    <= 1'b0;
    end else begin
      sunkDone <= 1'b0;
      if (startOfFrame) begin
        lat_x_r <= topLeftX;
        lat_y_r <= topLeftY;
      end
      if (respawn) begin
        state_r     <= ST_VISIBLE;
        frame_cnt_r <= 8'd0;
        visible     <= 1'b1;
      end else begin
        case (state_r)
          ST_VISIBLE: begin
            if (sunk) begin
              state_r     <= ST_FLASHING;
              frame_cnt_r <= 8'd0;
            end
            visible <= 1'b1;
          end
          ST_FLASHING: begin
            if (startOfFrame) begin
              if (frame_cnt_r == LAST_FRAME) begin
                state_r  <= ST_HIDDEN;
                visible  <= 1'b0;
                sunkDone <= 1'b1;
              end else begin
                frame_cnt_r <= frame_cnt_r + 8'd1;
              end
            end
          end
          ST_HIDDEN: begin
            visible <= 1'b0;
          end
          default: begin
            state_r     <= ST_VISIBLE;
            frame_cnt_r <= 8'd0;
            visible     <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule
